// File: rtl/pmod_dac_multich_pkg.sv
// Shared types and frame formatting for the multi-channel DAC121S101 driver.
package pmod_dac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int FRAME_W = 16;
  localparam int DAC_RES = 12;

  localparam logic [1:0] PD_NORMAL = 2'b00;
  localparam logic [1:0] PD_1K     = 2'b01;
  localparam logic [1:0] PD_100K   = 2'b10;
  localparam logic [1:0] PD_HIZ    = 2'b11;

  // Narrow samples are left-justified so the DAC sees full-scale range.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [1:0]         pd,
                                                     input logic [DAC_RES-1:0] samp,
                                                     input int unsigned        samp_w);
    logic [DAC_RES-1:0] w_just;
    w_just = samp << (DAC_RES - samp_w);
    return {2'b00, pd, w_just};
  endfunction

endpackage

// File: rtl/dac_sclk_gen.sv
// SCLK half-period tick generator; restarts on frame start so phase is deterministic.
module dac_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic i_restart,
  input  logic i_run,
  input  logic i_toggle_en,
  output logic o_tick,
  output logic o_sclk
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_sclk;

  assign o_tick = i_run && (r_cnt == LAST);
  assign o_sclk = r_sclk;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      r_cnt  <= '0;
      r_sclk <= 1'b1;
    end else begin
      if (i_restart || !i_run || o_tick) r_cnt <= '0;
      else                               r_cnt <= r_cnt + 1'b1;
      // SCLK parks high whenever toggling is not enabled (idle and sync gap).
      if (i_restart || !i_toggle_en) r_sclk <= 1'b1;
      else if (o_tick)               r_sclk <= ~r_sclk;
    end
  end

endmodule

// File: rtl/pmod_dac_multich.sv
// NUM_CH serial DAC driver sharing SCLK/SYNC, with valid/ready intake and auto-refresh.
module pmod_dac_multich
  import pmod_dac_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int DATA_W   = 12,
  parameter int CLK_DIV  = 4,
  parameter int SYNC_GAP = 2
) (
  input  logic                     CLK_i,
  input  logic                     ARESETN_i,
  input  logic [NUM_CH*DATA_W-1:0] DATA_i,
  input  logic [1:0]               PD_MODE_i,
  input  logic                     VALID_i,
  output logic                     READY_o,
  input  logic                     AUTO_i,
  output logic                     BUSY_o,
  output logic                     DONE_o,
  output logic                     DAC_SCLK_o,
  output logic                     DAC_SYNC_o,
  output logic [NUM_CH-1:0]        DAC_DIN_o
);

  if (DATA_W < 1 || DATA_W > DAC_RES) begin : g_bad_data_w
    $error("pmod_dac_multich: DATA_W must be in 1..12");
  end
  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("pmod_dac_multich: NUM_CH must be in 1..8");
  end

  localparam logic [5:0] SHIFT_LAST = 6'd31;
  localparam logic [5:0] GAP_LAST   = 6'(2*SYNC_GAP - 1);

  state_t                           r_state, w_nxt;
  logic [5:0]                       r_hp;
  logic [NUM_CH*DATA_W-1:0]         r_data;
  logic [1:0]                       r_pd;
  logic [NUM_CH-1:0][FRAME_W-1:0]   r_shreg;
  logic                             r_done;
  logic                             w_tick, w_sclk, w_accept, w_start, w_last_hp, w_shift;
  logic [NUM_CH*DATA_W-1:0]         w_src_data;
  logic [1:0]                       w_src_pd;

  assign w_accept   = (r_state == IDLE) && VALID_i;
  assign w_start    = (r_state == IDLE) && (VALID_i || AUTO_i);
  assign w_last_hp  = (r_state == SHIFT) ? (r_hp == SHIFT_LAST) : (r_hp == GAP_LAST);
  // DIN advances only on SCLK rising edges (tick while SCLK is low).
  assign w_shift    = (r_state == SHIFT) && w_tick && !w_sclk;
  assign w_src_data = w_accept ? DATA_i    : r_data;
  assign w_src_pd   = w_accept ? PD_MODE_i : r_pd;

  dac_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .gclk        (CLK_i),
    .grst_n      (ARESETN_i),
    .i_restart   (w_start),
    .i_run       (r_state != IDLE),
    .i_toggle_en (r_state == SHIFT),
    .o_tick      (w_tick),
    .o_sclk      (w_sclk)
  );

  always_ff @(posedge CLK_i or negedge ARESETN_i) begin
    if (!ARESETN_i) r_state <= IDLE;
    else            r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_start)               w_nxt = SHIFT;
      SHIFT:   if (w_tick && w_last_hp)   w_nxt = GAP;
      GAP:     if (w_tick && w_last_hp)   w_nxt = IDLE;
      default:                            w_nxt = IDLE;
    endcase
  end

  always_comb begin
    READY_o    = (r_state == IDLE);
    BUSY_o     = (r_state != IDLE);
    DAC_SYNC_o = (r_state != SHIFT);
    DAC_SCLK_o = w_sclk;
    DONE_o     = r_done;
    for (int ch = 0; ch < NUM_CH; ch++) DAC_DIN_o[ch] = r_shreg[ch][FRAME_W-1];
  end

  always_ff @(posedge CLK_i or negedge ARESETN_i) begin
    if (!ARESETN_i) begin
      r_hp   <= '0;
      r_done <= 1'b0;
      r_data <= '0;
      r_pd   <= PD_NORMAL;
    end else begin
      r_done <= (r_state == GAP) && w_tick && w_last_hp;
      if (w_start || (w_tick && w_last_hp)) r_hp <= '0;
      else if (w_tick)                      r_hp <= r_hp + 6'd1;
      if (w_accept) begin
        r_data <= DATA_i;
        r_pd   <= PD_MODE_i;
      end
    end
  end

  always_ff @(posedge CLK_i or negedge ARESETN_i) begin
    if (!ARESETN_i) begin
      r_shreg <= '0;
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (w_start)
          r_shreg[ch] <= build_frame(w_src_pd, DAC_RES'(w_src_data[ch*DATA_W +: DATA_W]), DATA_W);
        else if (w_shift)
          r_shreg[ch] <= {r_shreg[ch][FRAME_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_pmod_dac_multich.sv
// Randomized bench for pmod_dac_multich: frame-level scoreboard on a 2-channel DUT, direct capture on an 8-bit CLK_DIV=1 DUT.
module tb_pmod_dac_multich;

  localparam int NCH = 2, DW = 12, CD = 2, SG = 2;
  localparam int DTOT = NCH*DW;
  localparam int DWB = 8, CDB = 1, SGB = 1;

  logic            clk, rst_n;
  logic [DTOT-1:0] data;
  logic [1:0]      pd;
  logic            valid, auto;
  logic            ready, busy, done, sclk, sync;
  logic [NCH-1:0]  din;

  logic [DWB-1:0]  data_b;
  logic [1:0]      pd_b;
  logic            valid_b;
  logic            ready_b, busy_b, done_b, sclk_b, sync_b;
  logic [0:0]      din_b;

  int n_tests = 0, n_fail = 0;

  pmod_dac_multich #(.NUM_CH(NCH), .DATA_W(DW), .CLK_DIV(CD), .SYNC_GAP(SG)) u_dut (
    .CLK_i(clk), .ARESETN_i(rst_n), .DATA_i(data), .PD_MODE_i(pd), .VALID_i(valid),
    .READY_o(ready), .AUTO_i(auto), .BUSY_o(busy), .DONE_o(done),
    .DAC_SCLK_o(sclk), .DAC_SYNC_o(sync), .DAC_DIN_o(din)
  );

  pmod_dac_multich #(.NUM_CH(1), .DATA_W(DWB), .CLK_DIV(CDB), .SYNC_GAP(SGB)) u_dut_b (
    .CLK_i(clk), .ARESETN_i(rst_n), .DATA_i(data_b), .PD_MODE_i(pd_b), .VALID_i(valid_b),
    .READY_o(ready_b), .AUTO_i(1'b0), .BUSY_o(busy_b), .DONE_o(done_b),
    .DAC_SCLK_o(sclk_b), .DAC_SYNC_o(sync_b), .DAC_DIN_o(din_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Frame = 2 zero bits, PD, then the sample scaled up to 12 bits.
  function automatic logic [15:0] model_frame(input logic [1:0] p, input logic [11:0] s, input int w);
    return 16'(p*4096 + s*(1 << (12 - w)));
  endfunction

  // Scoreboard for u_dut: predicts each frame from the handshake/auto rules, then checks the wire-level frame.
  logic [15:0]         m_cap [NCH];
  logic [DTOT-1:0]     m_hd;
  logic [1:0]          m_hp;
  logic [NCH*16-1:0]   m_exp;
  logic [NCH*16-1:0]   m_q [$];
  int                  m_nbits = 0, m_low = 0, m_high = 0, m_since = 0, m_cyc = 0, m_start_cyc = 0;
  int                  m_rises = 0, m_dones = 0;
  bit                  m_b2b = 1'b0;
  logic                m_psclk = 1'b1, m_psync = 1'b1;

  always @(negedge clk) begin
    m_cyc++;
    if (!rst_n) begin
      m_q.delete();
      m_hd = '0; m_hp = '0; m_psclk = 1'b1; m_psync = 1'b1;
      m_b2b = 1'b0; m_nbits = 0; m_low = 0;
    end else begin
      if (m_psync && !sync) begin
        // Back-to-back: gap cycles plus the one IDLE handshake cycle.
        if (m_b2b) chk("b2b_sync_high", m_high, 2*SG*CD + 1);
        m_b2b = 1'b0; m_nbits = 0; m_low = 0;
      end
      if (!m_psync && sync) begin
        m_rises++;
        chk("sync_low_cycles", m_low, 32*CD);
        chk("bits_per_frame", m_nbits, 16);
        if (m_q.size() == 0) chk("frame_expected", 0, 1);
        else begin
          m_exp = m_q.pop_front();
          for (int ch = 0; ch < NCH; ch++) chk($sformatf("din%0d_word", ch), m_cap[ch], m_exp[ch*16 +: 16]);
        end
        m_high = 0; m_since = 0;
      end else m_since++;
      if (!sync) m_low++; else m_high++;
      if (!sync && m_psclk && !sclk) begin
        for (int ch = 0; ch < NCH; ch++) m_cap[ch] = {m_cap[ch][14:0], din[ch]};
        m_nbits++;
      end
      if (done) begin
        m_dones++;
        chk("done_after_sync_rise", m_since, 2*SG*CD);
        chk("done_after_start", m_cyc - m_start_cyc, 1 + (32 + 2*SG)*CD);
      end
      if (ready && (valid || auto)) begin
        if (valid) begin m_hd = data; m_hp = pd; end
        for (int ch = 0; ch < NCH; ch++) m_exp[ch*16 +: 16] = model_frame(m_hp, m_hd[ch*DW +: DW], DW);
        m_q.push_back(m_exp);
        m_start_cyc = m_cyc;
        if (done) m_b2b = 1'b1;
      end
      m_psclk = sclk; m_psync = sync;
    end
  end

  task automatic send(input logic [DTOT-1:0] d, input logic [1:0] p);
    int k;
    data = d; pd = p; valid = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!ready && k < 500);
    if (!ready) chk("send_timeout", 0, 1);
    @(posedge clk); #1 valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (!done && k < 2000);
    if (!done) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  // u_dut_b: one frame captured directly; optionally scrambles inputs right after accept.
  task automatic frame_b(input logic [7:0] d, input logic [1:0] p, input bit scramble, output logic [15:0] w);
    int k, c, ff, lf, nf;
    logic ps;
    data_b = d; pd_b = p; valid_b = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!ready_b && k < 100);
    if (!ready_b) chk("b_send_timeout", 0, 1);
    @(posedge clk); #1 valid_b = 1'b0;
    if (scramble) begin data_b = ~d; pd_b = ~p; end
    c = 0; nf = 0; ff = 0; lf = 0; ps = 1'b1; w = '0;
    while (c < 200) begin
      @(negedge clk); c++;
      if (sync_b) break;
      if (ps && !sclk_b) begin
        w = {w[14:0], din_b[0]};
        if (nf == 0) ff = c;
        lf = c; nf++;
      end
      ps = sclk_b;
    end
    chk("b_sync_low", c - 1, 32*CDB);
    chk("b_first_fall", ff, 1 + CDB);
    chk("b_fall_span", lf - ff, 15*2*CDB);
    chk("b_nbits", nf, 16);
    chk("b_frame", w, model_frame(p, d, DWB));
    while (!done_b && c < 300) begin @(negedge clk); c++; end
    chk("b_done_cycle", c, 1 + (32 + 2*SGB)*CDB);
    @(posedge clk); #1;
  endtask

  initial begin
    int k, falls;
    logic psc;
    logic [15:0] wb;
    rst_n = 1'b1; valid = 1'b0; auto = 1'b0; data = '0; pd = '0;
    data_b = '0; pd_b = '0; valid_b = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", ready, 1); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    chk("rst_sclk", sclk, 1);   chk("rst_sync", sync, 1); chk("rst_din", din, 0);
    chk("rst_b_ready", ready_b, 1); chk("rst_b_sync", sync_b, 1); chk("rst_b_din", din_b, 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    send({12'h123, 12'hABC}, 2'b00);
    wait_done();
    for (int i = 0; i < 4; i++) begin
      send(DTOT'($urandom), 2'($urandom));
      wait_done();
    end

    // VALID held high: each set accepted once, frames back-to-back
    valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data = DTOT'($urandom); pd = 2'($urandom);
      k = 0;
      do begin @(negedge clk); k++; end while (!ready && k < 500);
      if (!ready) chk("b2b_timeout", 0, 1);
      @(posedge clk); #1;
    end
    valid = 1'b0;
    wait_done();

    // Auto-refresh repeats 0x555, then new data offered in an IDLE cycle wins
    send({12'h555, 12'h555}, 2'b00);
    auto = 1'b1;
    wait_done();
    wait_done();
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!done && k < 2000);
    if (!done) chk("auto_idle_timeout", 0, 1);
    data = {12'h0AA, 12'h0AA}; pd = 2'b01; valid = 1'b1;
    @(posedge clk); #1 valid = 1'b0; auto = 1'b0;
    wait_done();

    // Reset at the 7th SCLK falling edge aborts the frame
    send(DTOT'($urandom), 2'($urandom));
    k = 0; falls = 0; psc = 1'b1;
    while (falls < 7 && k < 500) begin
      @(negedge clk); k++;
      if (psc && !sclk) falls++;
      psc = sclk;
    end
    chk("fall7_reached", falls, 7);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_sync", sync, 1); chk("midrst_sclk", sclk, 1); chk("midrst_din", din, 0);
    chk("midrst_busy", busy, 0); chk("midrst_ready", ready, 1);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    chk("post_rst_ready", ready, 1);
    send(DTOT'($urandom), 2'($urandom));
    wait_done();

    frame_b(8'hFF, 2'b11, 1'b0, wb);
    chk("b_ff_hiz_frame", wb, 16'h3FF0);
    for (int i = 0; i < 3; i++) frame_b(8'($urandom), 2'($urandom), 1'b1, wb);

    repeat (5) @(posedge clk);
    chk("queue_drained", m_q.size(), 0);
    chk("done_per_frame", m_dones, m_rises);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
